// File: rtl/sound_pkg.sv
// Shared constants for the sound subsystem: frame-step action masks and
// the default clock rates that set the frame divider.
package sound_pkg;

    localparam int CPU_HZ   = 4194304;
    localparam int FRAME_HZ = 512;

    // Bit n set means the strobe fires when frame step n executes
    localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
    localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

endpackage

// File: rtl/sound_tick_div.sv
// Modulo-N counter with synchronous clear, enable, a registered wrap strobe
// and combinational last-count / upper-half flags.
module sound_tick_div #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_last,
    output logic o_upper,
    output logic o_tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] r_cnt;
    logic         r_tick;

    assign o_last  = (r_cnt == W'(N - 1));
    assign o_upper = (r_cnt >= W'(N / 2));
    assign o_tick  = r_tick;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (i_en) begin
            r_cnt  <= o_last ? '0 : r_cnt + W'(1);
            r_tick <= o_last;
        end else begin
            r_tick <= 1'b0;
        end
    end

endmodule

// File: rtl/sound_frame_seq.sv
// APU timebase: divides the CPU clock into the 512 Hz frame step and the
// per-step length/sweep/envelope enables plus the frequency-divider tick.
module sound_frame_seq
    import sound_pkg::*;
#(
    parameter int FRAME_DIV = CPU_HZ / FRAME_HZ,
    parameter int FREQ_DIV  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       apu_on,
    input  logic       div_reset,
    output logic       tick_freq_div,
    output logic       tick_length,
    output logic       tick_sweep,
    output logic       tick_vol_env,
    output logic       frame_tick,
    output logic [2:0] step
);

    logic w_pre_last;
    logic w_pre_upper;
    logic w_pre_tick;
    logic w_fq_last;
    logic w_fq_upper;
    logic w_fq_tick;
    logic w_frame;
    logic w_unused;

    logic [2:0] r_step;
    logic       r_frame;
    logic       r_len;
    logic       r_sweep;
    logic       r_env;

    // A DIV write zeroes the prescaler; the frame rule only needs its old value
    sound_tick_div #(.N(FRAME_DIV)) u_pre (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!apu_on || div_reset),
        .i_en    (apu_on),
        .o_last  (w_pre_last),
        .o_upper (w_pre_upper),
        .o_tick  (w_pre_tick)
    );

    sound_tick_div #(.N(FREQ_DIV)) u_fq (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!apu_on),
        .i_en    (apu_on),
        .o_last  (w_fq_last),
        .o_upper (w_fq_upper),
        .o_tick  (w_fq_tick)
    );

    assign w_unused = ^{w_pre_tick, w_fq_last, w_fq_upper};

    // Natural wrap and a DIV write on the falling 512 Hz edge merge into one event
    assign w_frame = w_pre_last || (div_reset && w_pre_upper);

    always_ff @(posedge clk) begin
        if (rst || !apu_on) begin
            r_step  <= 3'd0;
            r_frame <= 1'b0;
            r_len   <= 1'b0;
            r_sweep <= 1'b0;
            r_env   <= 1'b0;
        end else begin
            r_frame <= w_frame;
            r_len   <= w_frame && LEN_STEPS[r_step];
            r_sweep <= w_frame && SWEEP_STEPS[r_step];
            r_env   <= w_frame && ENV_STEPS[r_step];
            if (w_frame) begin
                r_step <= r_step + 3'd1;
            end
        end
    end

    assign tick_freq_div = w_fq_tick;
    assign tick_length   = r_len;
    assign tick_sweep    = r_sweep;
    assign tick_vol_env  = r_env;
    assign frame_tick    = r_frame;
    assign step          = r_step;

endmodule

// File: tb/tb_sound_frame_seq.sv
// Self-checking bench for sound_frame_seq: a cycle model pushes expected
// outputs to a scoreboard queue, scenario tasks pop and compare them.
module tb_sound_frame_seq;

    localparam int FD = 1024;
    localparam int FQ = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       apu_on = 1'b0;
    logic       div_reset = 1'b0;
    logic       tick_freq_div;
    logic       tick_length;
    logic       tick_sweep;
    logic       tick_vol_env;
    logic       frame_tick;
    logic [2:0] step;
    logic [7:0] obs;

    int nChecks = 0;
    int nFail   = 0;
    int cyc     = 0;
    int mPre    = 0;
    int mFcnt   = 0;
    int mStep   = 0;
    logic [7:0] expQ[$];
    logic [7:0] expVal;

    sound_frame_seq #(.FRAME_DIV(FD), .FREQ_DIV(FQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .apu_on        (apu_on),
        .div_reset     (div_reset),
        .tick_freq_div (tick_freq_div),
        .tick_length   (tick_length),
        .tick_sweep    (tick_sweep),
        .tick_vol_env  (tick_vol_env),
        .frame_tick    (frame_tick),
        .step          (step)
    );

    always #5 clk = ~clk;

    assign obs = {tick_freq_div, tick_length, tick_sweep, tick_vol_env, frame_tick, step};

    // Drive one cycle of inputs, push the expected post-edge outputs, wait past the edge
    task automatic drive_cycle(input logic r, input logic on, input logic d);
        logic [7:0] e;
        logic ev;
        logic fq;
        rst       = r;
        apu_on    = on;
        div_reset = d;
        if (r || !on) begin
            mPre  = 0;
            mFcnt = 0;
            mStep = 0;
            e     = 8'd0;
        end else begin
            ev = (mPre == FD - 1) || (d && mPre >= FD / 2);
            fq = (mFcnt == FQ - 1);
            e  = {fq, ev && (mStep % 2 == 0), ev && (mStep == 2 || mStep == 6),
                  ev && (mStep == 7), ev, 3'b000};
            mFcnt = fq ? 0 : mFcnt + 1;
            mPre  = (d || mPre == FD - 1) ? 0 : mPre + 1;
            if (ev) mStep = (mStep + 1) % 8;
            e[2:0] = 3'(mStep);
        end
        expQ.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL reset cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
        end
        for (int i = 0; i < 20000; i++) begin
            drive_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL idle cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
        end
    endtask

    task automatic test_nominal();
        int k = 0;
        int nFreq = 0;
        for (int e = 1; e <= 8 * FD; e++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL nominal cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
            if (tick_freq_div) nFreq++;
            if (frame_tick) begin
                k++;
                nChecks++;
                if (e !== k * FD) begin
                    nFail++;
                    $display("[TB] FAIL frame_edge: got edge %0d expected %0d", e, k * FD);
                end
                nChecks++;
                if ({tick_length, tick_sweep, tick_vol_env, step} !==
                    {k[0], (k == 3 || k == 7), (k == 8), 3'(k % 8)}) begin
                    nFail++;
                    $display("[TB] FAIL step_actions k=%0d: got len=%b sw=%b env=%b step=%0d",
                             k, tick_length, tick_sweep, tick_vol_env, step);
                end
            end
        end
        nChecks++;
        if (k !== 8) begin
            nFail++;
            $display("[TB] FAIL frame_count: got %0d expected 8", k);
        end
        nChecks++;
        if (nFreq !== 8 * FD / FQ) begin
            nFail++;
            $display("[TB] FAIL freq_count: got %0d expected %0d", nFreq, 8 * FD / FQ);
        end
    endtask

    // Starts with prescaler at 0 and step 0; the DIV write lands in the upper half
    task automatic test_div_late();
        for (int i = 0; i < 5 * FD / 8; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL late_run cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b1);
        expVal = expQ.pop_front();
        nChecks++;
        if (obs !== expVal) begin
            nFail++;
            $display("[TB] FAIL late_div cycle %0d: got %b expected %b", cyc, obs, expVal);
        end
        nChecks++;
        if ({frame_tick, tick_length, step} !== {1'b1, 1'b1, 3'd1}) begin
            nFail++;
            $display("[TB] FAIL late_div_event: got frame=%b len=%b step=%0d expected 1 1 1",
                     frame_tick, tick_length, step);
        end
        for (int i = 1; i <= FD; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL late_after cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
            nChecks++;
            if (frame_tick !== (i == FD)) begin
                nFail++;
                $display("[TB] FAIL late_next_event edge %0d: got %b expected %b", i, frame_tick, (i == FD));
            end
        end
        nChecks++;
        if (step !== 3'd2) begin
            nFail++;
            $display("[TB] FAIL late_step: got %0d expected 2", step);
        end
    endtask

    task automatic test_div_early();
        for (int i = 0; i < FD / 8; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL early_run cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b1);
        expVal = expQ.pop_front();
        nChecks++;
        if (obs !== expVal) begin
            nFail++;
            $display("[TB] FAIL early_div cycle %0d: got %b expected %b", cyc, obs, expVal);
        end
        nChecks++;
        if ({frame_tick, tick_length, tick_sweep, tick_vol_env, step} !== {4'b0000, 3'd2}) begin
            nFail++;
            $display("[TB] FAIL early_no_tick: got frame=%b len=%b step=%0d expected 0 0 2",
                     frame_tick, tick_length, step);
        end
        for (int i = 1; i <= FD; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL early_after cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
            nChecks++;
            if (frame_tick !== (i == FD)) begin
                nFail++;
                $display("[TB] FAIL early_next_event edge %0d: got %b expected %b", i, frame_tick, (i == FD));
            end
        end
        nChecks++;
        if ({tick_length, tick_sweep, step} !== {1'b1, 1'b1, 3'd3}) begin
            nFail++;
            $display("[TB] FAIL early_step2_actions: got len=%b sw=%b step=%0d expected 1 1 3",
                     tick_length, tick_sweep, step);
        end
    endtask

    task automatic test_coincidence();
        int nFrames = 0;
        for (int i = 0; i < FD - 1; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL coin_run cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
            if (frame_tick) nFrames++;
        end
        drive_cycle(1'b0, 1'b1, 1'b1);
        expVal = expQ.pop_front();
        nChecks++;
        if (obs !== expVal) begin
            nFail++;
            $display("[TB] FAIL coin_div cycle %0d: got %b expected %b", cyc, obs, expVal);
        end
        if (frame_tick) nFrames++;
        nChecks++;
        if (step !== 3'd4) begin
            nFail++;
            $display("[TB] FAIL coin_step: got %0d expected 4", step);
        end
        for (int i = 0; i < FD - 1; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL coin_after cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
            if (frame_tick) nFrames++;
        end
        nChecks++;
        if (nFrames !== 1) begin
            nFail++;
            $display("[TB] FAIL coin_single_event: got %0d frame ticks expected 1", nFrames);
        end
    endtask

    task automatic test_power_cycle();
        int guard = 0;
        while (!(mStep == 5 && mPre == 3 * FD / 8) && guard < 10 * FD) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL power_run cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
            guard++;
        end
        nChecks++;
        if (guard >= 10 * FD) begin
            nFail++;
            $display("[TB] FAIL power_reach: got %0d cycles expected fewer than %0d", guard, 10 * FD);
        end
        nChecks++;
        if (step !== 3'd5) begin
            nFail++;
            $display("[TB] FAIL power_pre_step: got %0d expected 5", step);
        end
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== 8'd0) begin
                nFail++;
                $display("[TB] FAIL power_off cycle %0d: got %b expected %b", cyc, obs, 8'd0);
            end
        end
        for (int i = 1; i <= FD; i++) begin
            drive_cycle(1'b0, 1'b1, 1'b0);
            expVal = expQ.pop_front();
            nChecks++;
            if (obs !== expVal) begin
                nFail++;
                $display("[TB] FAIL power_on cycle %0d: got %b expected %b", cyc, obs, expVal);
            end
            nChecks++;
            if (frame_tick !== (i == FD)) begin
                nFail++;
                $display("[TB] FAIL power_first_event edge %0d: got %b expected %b", i, frame_tick, (i == FD));
            end
        end
        nChecks++;
        if ({tick_length, tick_sweep, tick_vol_env, step} !== {3'b100, 3'd1}) begin
            nFail++;
            $display("[TB] FAIL power_step0: got len=%b sw=%b env=%b step=%0d expected 1 0 0 1",
                     tick_length, tick_sweep, tick_vol_env, step);
        end
    endtask

    initial begin
        $display("[TB] sound_frame_seq bench start, FRAME_DIV=%0d FREQ_DIV=%0d", FD, FQ);
        test_reset();
        test_nominal();
        test_div_late();
        test_div_early();
        test_coincidence();
        test_power_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
